// File: rtl/dma_channel_scheduler.sv
// dma_channel_scheduler
//   Shares one burst engine between NUM_CH DMA channels. Each channel latches a
//   descriptor on ch_start; the scheduler splits transfers into bursts of at
//   most MAX_BURST beats, grants channels round-robin per burst and issues one
//   command at a time over cmd_valid/cmd_ready, waiting for cmd_done before
//   the next grant.
//
//   Optional feature macro: DMA_SCHED_PRIORITY_EN
//     defined   : channel 0 wins whenever busy, channels 1..3 round-robin.
//     undefined : pure round-robin over all channels.
//
//   Ports
//     clk_main_200mhz, reset_n (async, active low)
//     ch_start/ch_src_addr/ch_dst_addr/ch_length : per-channel descriptors
//     ch_busy, ch_done                          : per-channel status/pulse
//     cmd_valid/cmd_ready, cmd_ch/src/dst/beats : burst command handshake
//     cmd_done                                  : engine finished burst
//     sched_error                               : sticky cmd_done-outside-WAIT

// Per-channel context: descriptor capture and post-burst update.
module dma_ch_ctx #(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int BW         = 5,
  parameter int BEAT_BYTES = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              upd_i,
  input  logic [BW-1:0]     beats_i,
  output logic [ADDR_W-1:0] src_o,
  output logic [ADDR_W-1:0] dst_o,
  output logic [LEN_W-1:0]  rem_o,
  output logic              busy_o,
  output logic              done_o
);
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, step;
  logic [LEN_W-1:0]  rem_q, rem_d, beats_ext;
  logic              busy_q, busy_d, done_q, done_d;

  assign step      = ADDR_W'(beats_i) * ADDR_W'(BEAT_BYTES);
  assign beats_ext = LEN_W'(beats_i);

  always_comb begin
    src_d  = src_q;
    dst_d  = dst_q;
    rem_d  = rem_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i && !busy_q) begin
      // zero-length requests complete immediately without being captured
      if (len_i != '0) begin
        src_d  = src_i;
        dst_d  = dst_i;
        rem_d  = len_i;
        busy_d = 1'b1;
      end else begin
        done_d = 1'b1;
      end
    end else if (upd_i && busy_q) begin
      src_d = src_q + step;
      dst_d = dst_q + step;
      rem_d = rem_q - beats_ext;
      if (rem_q == beats_ext) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q  <= '0;
      dst_q  <= '0;
      rem_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      src_q  <= src_d;
      dst_q  <= dst_d;
      rem_q  <= rem_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign src_o  = src_q;
  assign dst_o  = dst_q;
  assign rem_o  = rem_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
endmodule

module dma_channel_scheduler #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int MAX_BURST  = 16,
  parameter int BEAT_BYTES = 4
) (
  input  logic                       clk_main_200mhz,
  input  logic                       reset_n,
  input  logic [NUM_CH-1:0]          ch_start,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_src_addr,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_dst_addr,
  input  logic [NUM_CH*LEN_W-1:0]    ch_length,
  output logic [NUM_CH-1:0]          ch_busy,
  output logic [NUM_CH-1:0]          ch_done,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [1:0]                 cmd_ch,
  output logic [ADDR_W-1:0]          cmd_src,
  output logic [ADDR_W-1:0]          cmd_dst,
  output logic [$clog2(MAX_BURST):0] cmd_beats,
  input  logic                       cmd_done,
  output logic                       sched_error
);
  localparam int BW = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t            state_q;
  logic [1:0]        last_grant_q, cmd_ch_q;
  logic              cmd_valid_q, err_q;
  logic [ADDR_W-1:0] cmd_src_q, cmd_dst_q;
  logic [BW-1:0]     cmd_beats_q;

  logic [NUM_CH-1:0][ADDR_W-1:0] ctx_src, ctx_dst;
  logic [NUM_CH-1:0][LEN_W-1:0]  ctx_rem;
  logic [NUM_CH-1:0]             ctx_upd;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ctx_upd[i] = (state_q == S_WAIT) && cmd_done && (cmd_ch_q == 2'(i));
    dma_ch_ctx #(
      .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BW(BW), .BEAT_BYTES(BEAT_BYTES)
    ) u_ctx (
      .clk_i   (clk_main_200mhz),
      .rst_ni  (reset_n),
      .start_i (ch_start[i]),
      .src_i   (ch_src_addr[i*ADDR_W +: ADDR_W]),
      .dst_i   (ch_dst_addr[i*ADDR_W +: ADDR_W]),
      .len_i   (ch_length[i*LEN_W +: LEN_W]),
      .upd_i   (ctx_upd[i]),
      .beats_i (cmd_beats_q),
      .src_o   (ctx_src[i]),
      .dst_o   (ctx_dst[i]),
      .rem_o   (ctx_rem[i]),
      .busy_o  (ch_busy[i]),
      .done_o  (ch_done[i])
    );
  end

  // Round-robin search from last_grant+1; k == NUM_CH wraps back to
  // last_grant itself so a lone busy channel keeps being served.
  logic [1:0]       gnt, idx;
  logic             gnt_vld;
  logic [LEN_W-1:0] gnt_rem;
  logic [BW-1:0]    gnt_beats;

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = last_grant_q;
    idx     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = last_grant_q + 2'(k);
      if (!gnt_vld && ch_busy[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
`ifdef DMA_SCHED_PRIORITY_EN
    if (ch_busy[0]) begin
      gnt_vld = 1'b1;
      gnt     = 2'd0;
    end
`endif
  end

  assign gnt_rem   = ctx_rem[gnt];
  assign gnt_beats = (gnt_rem > LEN_W'(MAX_BURST)) ? BW'(MAX_BURST) : BW'(gnt_rem);

  always_ff @(posedge clk_main_200mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 2'(NUM_CH - 1);
      cmd_valid_q  <= 1'b0;
      cmd_ch_q     <= '0;
      cmd_src_q    <= '0;
      cmd_dst_q    <= '0;
      cmd_beats_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      // a stray cmd_done only raises the flag; the FSM does not react to it
      if (cmd_done && state_q != S_WAIT) err_q <= 1'b1;
      case (state_q)
        S_IDLE: if (gnt_vld) begin
          cmd_ch_q     <= gnt;
          cmd_src_q    <= ctx_src[gnt];
          cmd_dst_q    <= ctx_dst[gnt];
          cmd_beats_q  <= gnt_beats;
          cmd_valid_q  <= 1'b1;
          last_grant_q <= gnt;
          state_q      <= S_ISSUE;
        end
        S_ISSUE: if (cmd_ready) begin
          cmd_valid_q <= 1'b0;
          state_q     <= S_WAIT;
        end
        S_WAIT: if (cmd_done) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_ch      = cmd_ch_q;
  assign cmd_src     = cmd_src_q;
  assign cmd_dst     = cmd_dst_q;
  assign cmd_beats   = cmd_beats_q;
  assign sched_error = err_q;
endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Scoreboard bench for dma_channel_scheduler: stimulus pushes the expected
// bursts of every accepted transfer into per-channel queues; a negedge
// monitor pops/compares on each handshake and tracks busy/done/error.
`define CHK(NM, A, E) begin n_chk++; if ((A) !== (E)) begin n_fail++; $display("FAIL %s: got %0h, expected %0h", NM, A, E); end end

module tb_dma_channel_scheduler;
  localparam int NC = 4, AW = 32, LW = 16, MB = 16, BB = 4;

  logic              clk = 1'b0, reset_n = 1'b0;
  logic [NC-1:0]     ch_start = '0;
  logic [NC*AW-1:0]  ch_src_addr = '0, ch_dst_addr = '0;
  logic [NC*LW-1:0]  ch_length = '0;
  logic [NC-1:0]     ch_busy, ch_done;
  logic              cmd_valid, cmd_ready, cmd_done, sched_error;
  logic [1:0]        cmd_ch;
  logic [AW-1:0]     cmd_src, cmd_dst;
  logic [4:0]        cmd_beats;

  dma_channel_scheduler dut (
    .clk_main_200mhz(clk), .reset_n(reset_n), .ch_start(ch_start),
    .ch_src_addr(ch_src_addr), .ch_dst_addr(ch_dst_addr), .ch_length(ch_length),
    .ch_busy(ch_busy), .ch_done(ch_done), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_beats(cmd_beats),
    .cmd_done(cmd_done), .sched_error(sched_error)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [31:0] src; logic [31:0] dst; logic [4:0] beats; } burst_t;

  burst_t    chq[NC][$];
  int        exp_gnt[$];
  int        done_log[$];
  logic [3:0] busy_exp = '0, done_exp = '0;
  logic      err_exp = 1'b0;
  bit        out_valid = 0, out_last = 0;
  int        out_ch = 0;
  int        n_chk = 0, n_fail = 0;
  bit        force_nready = 0, hold_done = 0, inj_done = 0;

  // Reference: a transfer is just the list of min(remaining, MB) chunks.
  task automatic push_bursts(input int c, input logic [31:0] s, input logic [31:0] d, input int len);
    int b;
    while (len > 0) begin
      b = (len > MB) ? MB : len;
      chq[c].push_back('{s, d, 5'(b)});
      s = s + 32'(b * BB);
      d = d + 32'(b * BB);
      len = len - b;
    end
  endtask

  // Monitor / scoreboard
  initial begin
    logic [3:0] busy_nx, done_nx;
    bit hold_v, prev_hs;
    logic [1:0] h_ch; logic [31:0] h_src, h_dst; logic [4:0] h_beats;
    burst_t e;
    int g;
    hold_v = 0; prev_hs = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        `CHK("rst_done", ch_done, 4'h0)
        `CHK("rst_valid", cmd_valid, 1'b0)
        for (int c = 0; c < NC; c++) chq[c].delete();
        exp_gnt.delete();
        busy_exp = '0; done_exp = '0; err_exp = 1'b0;
        out_valid = 0; hold_v = 0; prev_hs = 0;
      end else begin
        `CHK("busy", ch_busy, busy_exp)
        if ((ch_done | done_exp) != 4'h0) `CHK("done", ch_done, done_exp)
        `CHK("sched_error", sched_error, err_exp)
        if (hold_v) begin
          `CHK("hold_valid", cmd_valid, 1'b1)
          `CHK("hold_ch", cmd_ch, h_ch)
          `CHK("hold_src", cmd_src, h_src)
          `CHK("hold_dst", cmd_dst, h_dst)
          `CHK("hold_beats", cmd_beats, h_beats)
        end
        if (prev_hs) `CHK("valid_drop", cmd_valid, 1'b0)
        hold_v = cmd_valid && !cmd_ready;
        h_ch = cmd_ch; h_src = cmd_src; h_dst = cmd_dst; h_beats = cmd_beats;
        prev_hs = cmd_valid && cmd_ready;

        busy_nx = busy_exp;
        done_nx = '0;
        if (cmd_done) begin
          if (out_valid) begin
            if (out_last) begin
              busy_nx[out_ch] = 1'b0;
              done_nx[out_ch] = 1'b1;
              done_log.push_back(out_ch);
            end
            out_valid = 0;
          end else begin
            err_exp = 1'b1;
          end
        end
        for (int c = 0; c < NC; c++) begin
          if (ch_start[c] && !busy_exp[c]) begin
            if (ch_length[c*LW +: LW] == 16'h0) done_nx[c] = 1'b1;
            else begin
              busy_nx[c] = 1'b1;
              push_bursts(c, ch_src_addr[c*AW +: AW], ch_dst_addr[c*AW +: AW],
                          int'(ch_length[c*LW +: LW]));
            end
          end
        end
        if (cmd_valid && cmd_ready) begin
          if (chq[cmd_ch].size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL cmd_unexpected: got burst on ch %0d, expected none", cmd_ch);
          end else begin
            e = chq[cmd_ch].pop_front();
            `CHK("cmd_src", cmd_src, e.src)
            `CHK("cmd_dst", cmd_dst, e.dst)
            `CHK("cmd_beats", cmd_beats, e.beats)
            out_last  = (chq[cmd_ch].size() == 0);
            out_ch    = int'(cmd_ch);
            out_valid = 1;
          end
          if (exp_gnt.size() > 0) begin
            g = exp_gnt.pop_front();
            `CHK("grant", int'(cmd_ch), g)
          end
        end
        busy_exp = busy_nx;
        done_exp = done_nx;
      end
    end
  end

  // Burst engine model: random ready, random completion latency.
  initial begin
    bit acc, e_out; int e_lat;
    cmd_ready = 1'b0; cmd_done = 1'b0; e_out = 0; e_lat = 0;
    forever begin
      @(negedge clk);
      acc = reset_n && cmd_valid && cmd_ready;
      @(posedge clk); #1;
      cmd_done = 1'b0;
      if (!reset_n) begin
        e_out = 0; cmd_ready = 1'b0;
      end else begin
        if (acc) begin e_out = 1; e_lat = $urandom_range(0, 3); end
        if (inj_done) begin
          cmd_done = 1'b1; inj_done = 0;
        end else if (e_out && !hold_done) begin
          if (e_lat == 0) begin cmd_done = 1'b1; e_out = 0; end
          else e_lat--;
        end
        cmd_ready = force_nready ? 1'b0 : ($urandom_range(0, 9) < 7);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_ch(input int c, input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    ch_src_addr[c*AW +: AW] = s;
    ch_dst_addr[c*AW +: AW] = d;
    ch_length[c*LW +: LW]   = l;
  endtask

  task automatic start_mask(input logic [3:0] m);
    ch_start = m; cyc(1); ch_start = '0;
  endtask

  task automatic wait_idle();
    int t = 0;
    cyc(1);
    while ((busy_exp != 4'h0 || out_valid || cmd_valid) && t < 3000) begin cyc(1); t++; end
    `CHK("idle_timeout", t < 3000, 1'b1)
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    cyc(2);
    #2 reset_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    int t, qs;
    repeat (2) @(posedge clk); #1;
    `CHK("rst_cmd_valid", cmd_valid, 1'b0)
    `CHK("rst_cmd_ch", cmd_ch, 2'd0)
    `CHK("rst_cmd_src", cmd_src, 32'h0)
    `CHK("rst_cmd_dst", cmd_dst, 32'h0)
    `CHK("rst_cmd_beats", cmd_beats, 5'd0)
    `CHK("rst_busy", ch_busy, 4'h0)
    `CHK("rst_ch_done", ch_done, 4'h0)
    `CHK("rst_err", sched_error, 1'b0)
    #2 reset_n = 1'b1;
    cyc(1);

    // single transfer 40 beats -> 16/16/8, plus start-to-command latency
    set_ch(0, 32'h1000, 32'h2000, 16'd40);
    exp_gnt = {0, 0, 0};
    ch_start = 4'b0001;
    @(negedge clk); `CHK("lat_c0", cmd_valid, 1'b0)
    @(posedge clk); #1 ch_start = '0;
    @(negedge clk); `CHK("lat_c1", cmd_valid, 1'b0)
    @(negedge clk); `CHK("lat_c2", cmd_valid, 1'b1)
    wait_idle();
    `CHK("t1_grants_left", exp_gnt.size(), 0)

    // fairness: all four channels, 2 bursts each
    do_reset();
    done_log.delete();
    exp_gnt = {0, 1, 2, 3, 0, 1, 2, 3};
    for (int c = 0; c < NC; c++) set_ch(c, 32'h10000 * (c + 1), 32'h80000 + 32'h1000 * c, 16'd32);
    start_mask(4'hF);
    wait_idle();
    `CHK("fair_grants_left", exp_gnt.size(), 0)
    `CHK("fair_done_cnt", done_log.size(), 4)
    if (done_log.size() == 4)
      for (int i = 0; i < 4; i++) `CHK("fair_done_order", done_log[i], i)

    // backpressure: ready low for 5 cycles while valid
    force_nready = 1; cyc(1);
    set_ch(2, 32'h4000, 32'h5000, 16'd8);
    start_mask(4'b0100);
    t = 0;
    while (!cmd_valid && t < 10) begin cyc(1); t++; end
    `CHK("bp_valid_seen", cmd_valid, 1'b1)
    cyc(5);
    `CHK("bp_still_valid", cmd_valid, 1'b1)
    force_nready = 0;
    wait_idle();

    // zero length: done next cycle, no command
    set_ch(3, 32'h7000, 32'h7100, 16'd0);
    start_mask(4'b1000);
    for (int i = 0; i < 4; i++) begin `CHK("len0_no_cmd", cmd_valid, 1'b0) cyc(1); end

    // start while busy is ignored
    set_ch(1, 32'h100, 32'h200, 16'd40);
    start_mask(4'b0010);
    cyc(2);
    set_ch(1, 32'h9000, 32'h9100, 16'd5);
    start_mask(4'b0010);
    wait_idle();

    // address wrap
    set_ch(2, 32'hFFFF_FFF8, 32'hFFFF_FFF0, 16'd20);
    start_mask(4'b0100);
    wait_idle();

    // cmd_done while idle -> sticky error
    @(negedge clk) inj_done = 1;
    cyc(6);
    `CHK("err_sticky", sched_error, 1'b1)
    `CHK("err_no_busy", ch_busy, 4'h0)
    `CHK("err_no_cmd", cmd_valid, 1'b0)

    // reset in the middle of WAIT
    hold_done = 1;
    set_ch(1, 32'hA000, 32'hB000, 16'd16);
    start_mask(4'b0010);
    t = 0;
    while (!out_valid && t < 50) begin cyc(1); t++; end
    `CHK("rw_reached_wait", out_valid, 1'b1)
    cyc(1);
    #2 reset_n = 1'b0;
    #1;
    `CHK("rw_valid", cmd_valid, 1'b0)
    `CHK("rw_ch", cmd_ch, 2'd0)
    `CHK("rw_src", cmd_src, 32'h0)
    `CHK("rw_dst", cmd_dst, 32'h0)
    `CHK("rw_beats", cmd_beats, 5'd0)
    `CHK("rw_busy", ch_busy, 4'h0)
    `CHK("rw_done", ch_done, 4'h0)
    `CHK("rw_err", sched_error, 1'b0)
    cyc(3);
    #2 reset_n = 1'b1;
    hold_done = 0;
    cyc(3);

    // arbitration mode check, starting from reset state
`ifdef DMA_SCHED_PRIORITY_EN
    exp_gnt = {0, 0, 0, 1};
`else
    exp_gnt = {0, 1, 0, 0};
`endif
    set_ch(0, 32'h0, 32'h8000, 16'd48);
    set_ch(1, 32'h100000, 32'h200000, 16'd16);
    start_mask(4'b0011);
    wait_idle();
    `CHK("prio_grants_left", exp_gnt.size(), 0)

    // randomized traffic
    repeat (400) begin
      for (int c = 0; c < NC; c++) begin
        set_ch(c, $urandom, $urandom,
               ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 60)));
        ch_start[c] = ($urandom_range(0, 5) == 0);
      end
      cyc(1);
    end
    ch_start = '0;
    wait_idle();
    qs = 0;
    for (int c = 0; c < NC; c++) qs += chq[c].size();
    `CHK("rand_queues_empty", qs, 0)

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
